// File: rtl/axi3_pkg.sv
// Shared AXI3 encodings and the write-responder FSM state codes.
package axi3_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_EXOKAY = 2'b01;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   localparam logic [1:0] BURST_INCR = 2'b01;
   localparam logic [2:0] SIZE_4B    = 3'b010;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] DATA = 2'd1;
   localparam logic [1:0] RESP = 2'd2;

   // DECERR outranks SLVERR, which outranks OKAY.
   function automatic logic [1:0] resp_code(input logic dec, input logic slv);
      if (dec) return RESP_DECERR;
      if (slv) return RESP_SLVERR;
      return RESP_OKAY;
   endfunction

endpackage

// File: rtl/wr_slv_ram.sv
// Byte-enable write / registered read RAM backing the write-responder window.
module wr_slv_ram #(
   parameter int unsigned ADDR_BITS = 10
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 we_i,
   input  logic [3:0]           be_i,
   input  logic [ADDR_BITS-1:0] waddr_i,
   input  logic [31:0]          wdata_i,
   input  logic [ADDR_BITS-1:0] raddr_i,
   output logic [31:0]          rdata_o
);

   logic [31:0] mem [2**ADDR_BITS];
   logic [31:0] rdata_q;

   always_ff @(posedge clk_i) begin
      if (we_i) begin
         for (int b = 0; b < 4; b++) begin
            if (be_i[b]) mem[waddr_i][8*b +: 8] <= wdata_i[8*b +: 8];
         end
      end
   end

   // Read-before-write: a same-cycle write to raddr_i returns the old word.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) rdata_q <= '0;
      else         rdata_q <= mem[raddr_i];
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/axi_hp_wr_slave.sv
// AXI3 write responder terminating HP0-style bursts into a local RAM window.
// Define AXI_WR_SLV_STALL_EN to add LFSR-driven pseudo-random W backpressure.
module axi_hp_wr_slave
   import axi3_pkg::*;
#(
   parameter int unsigned ADDR_BITS = 10,
   parameter logic [31:0] BASE_ADDR = 32'h1E00_0000,
   parameter int unsigned ID_W      = 6
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [31:0]          AXI_awaddr,
   input  logic [ID_W-1:0]      AXI_awid,
   input  logic [3:0]           AXI_awlen,
   input  logic [2:0]           AXI_awsize,
   input  logic [1:0]           AXI_awburst,
   input  logic                 AXI_awvalid,
   output logic                 AXI_awready,
   input  logic [31:0]          AXI_wdata,
   input  logic [3:0]           AXI_wstrb,
   input  logic [ID_W-1:0]      AXI_wid,
   input  logic                 AXI_wlast,
   input  logic                 AXI_wvalid,
   output logic                 AXI_wready,
   output logic [ID_W-1:0]      AXI_bid,
   output logic [1:0]           AXI_bresp,
   output logic                 AXI_bvalid,
   input  logic                 AXI_bready,
   input  logic [ADDR_BITS-1:0] dbg_addr,
   output logic [31:0]          dbg_data,
   output logic [31:0]          burst_cnt,
   output logic [15:0]          err_cnt
);

   logic [1:0]           state_q, state_d;
   logic                 awready_q, wready_q, bvalid_q;
   logic [ID_W-1:0]      id_q, bid_q;
   logic [1:0]           bresp_q;
   logic [3:0]           len_q, beat_q;
   logic [ADDR_BITS-1:0] idx_q;
   logic                 dec_q, slv_q;
   logic [31:0]          burst_cnt_q;
   logic [15:0]          err_cnt_q;

   logic aw_fire, w_fire, b_fire, beat_last, w_term, beat_err, aw_dec, aw_slv, ram_we;
   logic wready;
   logic unused_awaddr;

   assign unused_awaddr = ^AXI_awaddr[1:0];

`ifdef AXI_WR_SLV_STALL_EN
   logic [15:0] lfsr_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) lfsr_q <= 16'hACE1;
      else        lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
   end

   assign wready = wready_q & ~lfsr_q[0];
`else
   assign wready = wready_q;
`endif

   assign aw_fire   = AXI_awvalid & awready_q;
   assign w_fire    = AXI_wvalid & wready;
   assign b_fire    = bvalid_q & AXI_bready;
   assign beat_last = (beat_q == len_q);
   assign w_term    = w_fire & (beat_last | AXI_wlast);
   // Early wlast, missing wlast and a foreign wid all downgrade the burst to SLVERR.
   assign beat_err  = (AXI_wid != id_q) | (AXI_wlast != beat_last);
   assign aw_dec    = AXI_awaddr[31:ADDR_BITS+2] != BASE_ADDR[31:ADDR_BITS+2];
   assign aw_slv    = (AXI_awsize != SIZE_4B) | (AXI_awburst != BURST_INCR);
   assign ram_we    = w_fire & ~dec_q & ~slv_q;

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (aw_fire) state_d = DATA;
         DATA:    if (w_term)  state_d = RESP;
         RESP:    if (b_fire)  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         awready_q   <= 1'b0;
         wready_q    <= 1'b0;
         bvalid_q    <= 1'b0;
         id_q        <= '0;
         bid_q       <= '0;
         bresp_q     <= RESP_OKAY;
         len_q       <= '0;
         beat_q      <= '0;
         idx_q       <= '0;
         dec_q       <= 1'b0;
         slv_q       <= 1'b0;
         burst_cnt_q <= '0;
         err_cnt_q   <= '0;
      end else begin
         state_q   <= state_d;
         awready_q <= (state_d == IDLE);
         wready_q  <= (state_d == DATA);
         bvalid_q  <= (state_d == RESP);
         if (aw_fire) begin
            id_q   <= AXI_awid;
            len_q  <= AXI_awlen;
            idx_q  <= AXI_awaddr[ADDR_BITS+1:2];
            beat_q <= '0;
            dec_q  <= aw_dec;
            slv_q  <= aw_slv;
         end
         if (w_fire) begin
            beat_q <= beat_q + 4'd1;
            idx_q  <= idx_q + ADDR_BITS'(1);
            if (beat_err) slv_q <= 1'b1;
         end
         if (w_term) begin
            bid_q   <= id_q;
            bresp_q <= resp_code(dec_q, slv_q | beat_err);
         end
         if (b_fire) begin
            burst_cnt_q <= burst_cnt_q + 32'd1;
            if (bresp_q != RESP_OKAY && err_cnt_q != 16'hFFFF) err_cnt_q <= err_cnt_q + 16'd1;
         end
      end
   end

   wr_slv_ram #(
      .ADDR_BITS(ADDR_BITS)
   ) u_ram (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .we_i   (ram_we),
      .be_i   (AXI_wstrb),
      .waddr_i(idx_q),
      .wdata_i(AXI_wdata),
      .raddr_i(dbg_addr),
      .rdata_o(dbg_data)
   );

   assign AXI_awready = awready_q;
   assign AXI_wready  = wready;
   assign AXI_bvalid  = bvalid_q;
   assign AXI_bid     = bid_q;
   assign AXI_bresp   = bresp_q;
   assign burst_cnt   = burst_cnt_q;
   assign err_cnt     = err_cnt_q;

endmodule

// File: tb/tb_axi_hp_wr_slave.sv
// Scoreboard bench for axi_hp_wr_slave: driver pushes expected B responses, monitor pops them.
module tb_axi_hp_wr_slave;

   localparam int unsigned AB    = 10;
   localparam int unsigned DEPTH = 2**AB;
   localparam int unsigned IDW   = 6;
   localparam logic [31:0] BASE  = 32'h1E00_0000;

   logic            clk, rst_n;
   logic [31:0]     AXI_awaddr;
   logic [IDW-1:0]  AXI_awid;
   logic [3:0]      AXI_awlen;
   logic [2:0]      AXI_awsize;
   logic [1:0]      AXI_awburst;
   logic            AXI_awvalid, AXI_awready;
   logic [31:0]     AXI_wdata;
   logic [3:0]      AXI_wstrb;
   logic [IDW-1:0]  AXI_wid;
   logic            AXI_wlast, AXI_wvalid, AXI_wready;
   logic [IDW-1:0]  AXI_bid;
   logic [1:0]      AXI_bresp;
   logic            AXI_bvalid, AXI_bready;
   logic [AB-1:0]   dbg_addr;
   logic [31:0]     dbg_data, burst_cnt;
   logic [15:0]     err_cnt;

   axi_hp_wr_slave #(.ADDR_BITS(AB), .BASE_ADDR(BASE), .ID_W(IDW)) dut (
      .clk(clk), .rst_n(rst_n),
      .AXI_awaddr(AXI_awaddr), .AXI_awid(AXI_awid), .AXI_awlen(AXI_awlen),
      .AXI_awsize(AXI_awsize), .AXI_awburst(AXI_awburst), .AXI_awvalid(AXI_awvalid),
      .AXI_awready(AXI_awready), .AXI_wdata(AXI_wdata), .AXI_wstrb(AXI_wstrb),
      .AXI_wid(AXI_wid), .AXI_wlast(AXI_wlast), .AXI_wvalid(AXI_wvalid),
      .AXI_wready(AXI_wready), .AXI_bid(AXI_bid), .AXI_bresp(AXI_bresp),
      .AXI_bvalid(AXI_bvalid), .AXI_bready(AXI_bready), .dbg_addr(dbg_addr),
      .dbg_data(dbg_data), .burst_cnt(burst_cnt), .err_cnt(err_cnt)
   );

   int unsigned n_cmp = 0, n_fail = 0;
   int unsigned cyc = 0, aw_cyc = 0, b_cyc = 0, bh_cyc = 0;
   int unsigned bmode = 1;  // 0: bready low, 1: high, 2: random
   bit          b_seen = 0;
   logic [31:0] mem_m [DEPTH];
   logic [7:0]  exp_q [$];  // {bid, bresp}
   int unsigned exp_burst = 0, exp_err = 0;
   bit          m_dec, m_slv;
   int unsigned m_idx;

   initial begin
      clk = 0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #2000000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic timeout(input string name);
      n_cmp++;
      n_fail++;
      $display("FAIL %s: timed out at cycle %0d", name, cyc);
   endtask

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   // B-ready driver
   initial forever begin
      @(negedge clk);
      #1;
      AXI_bready = (bmode == 0) ? 1'b0 : (bmode == 1) ? 1'b1 : 1'($urandom_range(0, 1));
   end

   // Monitor: checks every presented B response against the scoreboard queue.
   initial forever begin
      logic [7:0] e;
      @(negedge clk);
      #2;
      if (!rst_n) b_seen = 0;
      else if (AXI_bvalid) begin
         if (!b_seen) begin
            b_seen = 1;
            b_cyc  = cyc;
         end
         chk("awready_during_resp", 32'(AXI_awready), 32'd0);
         if (exp_q.size() == 0) begin
            timeout("unexpected_b");
         end else begin
            e = exp_q[0];
            chk("bid", 32'(AXI_bid), 32'(e[7:2]));
            chk("bresp", 32'(AXI_bresp), 32'(e[1:0]));
            if (AXI_bready) begin
               void'(exp_q.pop_front());
               exp_burst++;
               if (e[1:0] != 2'b00 && exp_err < 16'hFFFF) exp_err++;
               bh_cyc = cyc;
               b_seen = 0;
            end
         end
      end
   end

   // Reference model of the window: decode, per-burst error flags, byte-strobe writes.
   task automatic model_aw(input logic [31:0] addr, input logic [2:0] size, input logic [1:0] bt);
      m_dec = (addr >> (AB + 2)) != (BASE >> (AB + 2));
      m_slv = (size != 3'd2) || (bt != 2'b01);
      m_idx = (addr >> 2) % DEPTH;
   endtask

   task automatic model_beat(input logic [31:0] d, input logic [3:0] s, input logic [5:0] wid,
                             input logic [5:0] id, input bit wl, input int b, input int len);
      if (!m_dec && !m_slv)
         for (int k = 0; k < 4; k++) if (s[k]) mem_m[m_idx][8*k +: 8] = d[8*k +: 8];
      if (wid != id) m_slv = 1;
      if (wl && b < len) m_slv = 1;
      if (b == len && !wl) m_slv = 1;
      m_idx = (m_idx + 1) % DEPTH;
   endtask

   task automatic do_aw(input logic [31:0] addr, input logic [5:0] id, input logic [3:0] len,
                        input logic [2:0] size, input logic [1:0] bt, output bit ok);
      AXI_awaddr = addr; AXI_awid = id; AXI_awlen = len; AXI_awsize = size; AXI_awburst = bt;
      AXI_awvalid = 1; ok = 0;
      for (int t = 0; t < 400; t++) begin
         if (AXI_awready) begin
            aw_cyc = cyc;
            ok = 1;
            tick();
            break;
         end
         tick();
      end
      AXI_awvalid = 0;
      if (!ok) timeout("aw_handshake");
   endtask

   task automatic do_w(input logic [31:0] d, input logic [3:0] s, input logic [5:0] wid,
                       input bit wl, input logic [5:0] id, input int b, input int len,
                       input bit gaps, output bit ok);
      if (gaps) repeat ($urandom_range(0, 2)) tick();
      AXI_wdata = d; AXI_wstrb = s; AXI_wid = wid; AXI_wlast = wl; AXI_wvalid = 1; ok = 0;
      for (int t = 0; t < 200; t++) begin
         if (AXI_wready) begin
            model_beat(d, s, wid, id, wl, b, len);
            ok = 1;
            tick();
            break;
         end
         tick();
      end
      AXI_wvalid = 0;
      if (!ok) timeout("w_handshake");
   endtask

   // dmode: 0 random, 1 beat index, 2 all-ones, 3 zero. s_fix==0 selects random strobes.
   task automatic run_burst(input logic [31:0] addr, input logic [5:0] id, input int len,
                            input logic [2:0] size, input logic [1:0] bt, input int werr,
                            input int wlast_at, input int dmode, input logic [3:0] s_fix,
                            input bit gaps);
      bit ok;
      logic [31:0] d;
      logic [3:0]  s;
      bit wl;
      do_aw(addr, id, 4'(len), size, bt, ok);
      if (!ok) return;
      model_aw(addr, size, bt);
      for (int b = 0; b < 16; b++) begin
         d  = (dmode == 0) ? $urandom : (dmode == 1) ? 32'(b) : (dmode == 2) ? '1 : '0;
         s  = (s_fix == 0) ? 4'($urandom) : s_fix;
         wl = (b == wlast_at);
         do_w(d, s, (b == werr) ? id ^ 6'h01 : id, wl, id, b, len, gaps, ok);
         if (!ok) return;
         if (b == len || wl) break;
      end
      exp_q.push_back({id, m_dec ? 2'b11 : m_slv ? 2'b10 : 2'b00});
   endtask

   task automatic wait_idle();
      for (int t = 0; t < 600; t++) begin
         if (exp_q.size() == 0 && AXI_awready) return;
         tick();
      end
      timeout("wait_idle");
   endtask

   task automatic check_counts(input string tag);
      chk({tag, "_burst_cnt"}, burst_cnt, exp_burst);
      chk({tag, "_err_cnt"}, 32'(err_cnt), exp_err);
   endtask

   task automatic check_mem(input int lo, input int n);
      for (int i = 0; i < n; i++) begin
         dbg_addr = AB'((lo + i) % DEPTH);
         tick();
         chk("dbg_data", dbg_data, mem_m[(lo + i) % DEPTH]);
      end
   endtask

   task automatic do_reset();
      AXI_awvalid = 0; AXI_wvalid = 0; rst_n = 0;
      #1;
      chk("rst_awready", 32'(AXI_awready), 0);
      chk("rst_wready", 32'(AXI_wready), 0);
      chk("rst_bvalid", 32'(AXI_bvalid), 0);
      chk("rst_bid", 32'(AXI_bid), 0);
      chk("rst_bresp", 32'(AXI_bresp), 0);
      chk("rst_burst_cnt", burst_cnt, 0);
      chk("rst_err_cnt", 32'(err_cnt), 0);
      chk("rst_dbg_data", dbg_data, 0);
      exp_q.delete(); exp_burst = 0; exp_err = 0;
      tick(); tick();
      rst_n = 1;
      chk("awready_before_edge", 32'(AXI_awready), 0);
      tick();
      chk("awready_first_cycle", 32'(AXI_awready), 1);
   endtask

   initial begin
      bit ok;
      int kind, len, werr, wl_at;
      logic [31:0] addr;
      rst_n = 0; AXI_awvalid = 0; AXI_wvalid = 0; AXI_awaddr = 0; AXI_awid = 0; AXI_awlen = 0;
      AXI_awsize = 0; AXI_awburst = 0; AXI_wdata = 0; AXI_wstrb = 0; AXI_wid = 0;
      AXI_wlast = 0; AXI_bready = 1; dbg_addr = 0;
      for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
      tick();
      do_reset();

      // Zero the RAM so later strobe checks start from known contents.
      for (int i = 0; i < DEPTH / 16; i++)
         run_burst(BASE + 32'(i * 64), 6'h3F, 15, 3'd2, 2'b01, -1, 15, 3, 4'hF, 0);
      wait_idle();
      tick();
      do_reset();

      // Bring-up: full 16-beat burst, latency, readback.
      bmode = 1;
      run_burst(BASE, 6'h05, 15, 3'd2, 2'b01, -1, 15, 1, 4'hF, 0);
      for (int t = 0; t < 50 && !AXI_awready; t++) tick();
`ifndef AXI_WR_SLV_STALL_EN
      chk("bvalid_latency", b_cyc - aw_cyc, 17);
      chk("awready_latency", cyc - aw_cyc, 18);
`endif
      wait_idle();
      tick();
      check_counts("bringup");
      check_mem(0, 16);

      // Strobe + window wrap.
      run_burst(BASE + 32'(4 * (DEPTH - 2)), 6'h11, 3, 3'd2, 2'b01, -1, 3, 2, 4'b0011, 0);
      wait_idle();
      check_mem(DEPTH - 2, 4);
      dbg_addr = AB'(DEPTH - 1);
      tick();
      chk("wrap_word_const", dbg_data, 32'h0000_FFFF);

      // Decode error, burst-type error, early wlast, wid mismatch, missing wlast.
      run_burst(BASE + 32'h0100_0000, 6'h21, 3, 3'd2, 2'b01, -1, 3, 0, 4'hF, 0);
      wait_idle();
      tick();
      check_counts("decerr");
      check_mem(0, 4);
      run_burst(BASE + 32'h40, 6'h22, 3, 3'd2, 2'b00, -1, 3, 0, 4'hF, 0);
      run_burst(BASE + 32'h80, 6'h23, 7, 3'd2, 2'b01, -1, 3, 0, 4'hF, 0);
      run_burst(BASE + 32'hC0, 6'h24, 3, 3'd2, 2'b01, 2, 3, 0, 4'hF, 0);
      run_burst(BASE + 32'h100, 6'h25, 3, 3'd2, 2'b01, -1, -1, 0, 4'hF, 0);
      wait_idle();
      tick();
      check_counts("proterr");
      check_mem(16, 72);

      // B backpressure: next AW must land the cycle after the B handshake.
      bmode = 0;
      run_burst(BASE + 32'h200, 6'h2A, 1, 3'd2, 2'b01, -1, 1, 0, 4'hF, 0);
      fork
         begin
            repeat (20) tick();
            bmode = 1;
         end
         run_burst(BASE + 32'h240, 6'h2B, 0, 3'd2, 2'b01, -1, 0, 0, 4'hF, 0);
      join
      chk("aw_after_b", aw_cyc, bh_cyc + 1);
      wait_idle();

      // Randomized traffic with gaps and random bready.
      bmode = 2;
      for (int n = 0; n < 40; n++) begin
         kind  = $urandom_range(0, 9);
         len   = $urandom_range(0, 15);
         addr  = BASE + ($urandom_range(0, DEPTH - 1) << 2) + $urandom_range(0, 3);
         werr  = (kind == 2) ? $urandom_range(0, len) : -1;
         wl_at = (kind == 3 && len > 0) ? $urandom_range(0, len - 1) : (kind == 4) ? -1 : len;
         if (kind == 0) addr = addr ^ (32'd1 << $urandom_range(AB + 2, 31));
         run_burst(addr, 6'($urandom), len, (kind == 1) ? 3'd1 : 3'd2, 2'b01, werr, wl_at,
                   0, 4'h0, 1);
      end
      wait_idle();
      tick();
      check_counts("random");
      check_mem(0, DEPTH);

      // Mid-burst reset after five beats, then a clean full burst.
      bmode = 1;
      do_aw(BASE + 32'h300, 6'h33, 4'd15, 3'd2, 2'b01, ok);
      model_aw(BASE + 32'h300, 3'd2, 2'b01);
      for (int b = 0; b < 5 && ok; b++) do_w($urandom, 4'hF, 6'h33, 0, 6'h33, b, 15, 0, ok);
      do_reset();
      run_burst(BASE + 32'h380, 6'h34, 15, 3'd2, 2'b01, -1, 15, 0, 4'hF, 0);
      wait_idle();
      tick();
      check_counts("post_reset");
      check_mem(0, DEPTH);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
